// File: rtl/isp_crop_stride.sv
// Window crop with column/row decimation and regenerated fstart/hstart; `CROP_SHADOW_CFG_EN latches config per frame.
// Latency 2 cycles, 1 beat/cycle; both stages hold while S2 is occupied and in_ready is low.
module isp_crop_stride #(
  parameter int COLOR_DEPTH = 16,
  parameter int CHANNELS    = 3,
  parameter int COORD_W     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS*COLOR_DEPTH-1:0] in_data,
  input  logic [7:0]                      in_user,
  input  logic                            in_valid,
  output logic                            out_ready,
  output logic [CHANNELS*COLOR_DEPTH-1:0] out_data,
  output logic [7:0]                      out_user,
  output logic                            out_valid,
  input  logic                            in_ready,
  input  logic [15:0]                     isp_ctrl,
  input  logic [COORD_W-1:0]              isp_out_offset_x,
  input  logic [COORD_W-1:0]              isp_out_offset_y,
  input  logic [COORD_W-1:0]              isp_out_pixel_x,
  input  logic [COORD_W-1:0]              isp_out_pixel_y,
  input  logic [7:0]                      isp_crop_step,
  output logic                            frame_done
);

  localparam int DW = CHANNELS * COLOR_DEPTH;
  localparam logic [COORD_W-1:0] CNT_ONE = COORD_W'(1);
  localparam logic [COORD_W:0]   LIM_ONE = (COORD_W + 1)'(1);
  localparam logic [3:0]         PH_ONE  = 4'd1;

  logic               act_q;
  logic [COORD_W-1:0] offx_q, offy_q, pw_q, ph_q;
  logic [3:0]         sx_q, sy_q;

  logic [COORD_W-1:0] cnt_x_q, cnt_y_q, cnt_x_d, cnt_y_d;
  logic [3:0]         phx_q, phy_q, phx_d, phy_d;
  logic               first_q;

  logic               v1_q, pass1_q, last1_q, v2_q, pass2_q, last2_q;
  logic [DW-1:0]      dat1_q, dat2_q;
  logic [7:0]         usr1_q, usr2_q;

  logic run, acc, fs, hs, frm_rst, cfg_load, use_live, live_act;
  logic               u_act;
  logic [COORD_W-1:0] u_offx, u_offy, u_pw, u_ph;
  logic [3:0]         u_sx, u_sy;
  logic [COORD_W:0]   end_x, end_y, lim_x, lim_y;
  logic               in_x, in_y, keep, hs_k, fs_k, last_k;
  logic               unused_ctrl;

  assign unused_ctrl = ^{isp_ctrl[15:8], isp_ctrl[6:1]};

  assign run       = in_ready | ~v2_q;
  assign out_ready = run;
  assign acc       = in_valid & run;
  assign fs        = in_user[1];
  assign hs        = in_user[0];
  assign frm_rst   = fs | first_q;
  assign live_act  = isp_ctrl[0] & isp_ctrl[7];

`ifdef CROP_SHADOW_CFG_EN
  // The frame-start beat itself already sees the values it latches.
  assign cfg_load = acc & fs;
  assign use_live = fs;
`else
  assign cfg_load = 1'b1;
  assign use_live = 1'b0;
`endif

  assign u_act  = use_live ? live_act         : act_q;
  assign u_offx = use_live ? isp_out_offset_x : offx_q;
  assign u_offy = use_live ? isp_out_offset_y : offy_q;
  assign u_pw   = use_live ? isp_out_pixel_x  : pw_q;
  assign u_ph   = use_live ? isp_out_pixel_y  : ph_q;
  assign u_sx   = use_live ? isp_crop_step[3:0] : sx_q;
  assign u_sy   = use_live ? isp_crop_step[7:4] : sy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q  <= 1'b0;
      offx_q <= '0;
      offy_q <= '0;
      pw_q   <= '0;
      ph_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
    end else if (cfg_load) begin
      act_q  <= live_act;
      offx_q <= isp_out_offset_x;
      offy_q <= isp_out_offset_y;
      pw_q   <= isp_out_pixel_x;
      ph_q   <= isp_out_pixel_y;
      sx_q   <= isp_crop_step[3:0];
      sy_q   <= isp_crop_step[7:4];
    end
  end

  assign cnt_x_d = (frm_rst | hs) ? '0 : ((&cnt_x_q) ? cnt_x_q : cnt_x_q + CNT_ONE);
  assign cnt_y_d = frm_rst ? '0 : (hs ? ((&cnt_y_q) ? cnt_y_q : cnt_y_q + CNT_ONE) : cnt_y_q);

  // Phases realign at the window origin so decimation is anchored to offset, not to frame edge.
  assign phx_d = (cnt_x_d == u_offx) ? 4'd0 : ((phx_q == u_sx) ? 4'd0 : phx_q + PH_ONE);
  assign phy_d = (cnt_y_d == u_offy) ? 4'd0 :
                 (!(frm_rst | hs)) ? phy_q : ((phy_q == u_sy) ? 4'd0 : phy_q + PH_ONE);

  assign end_x = {1'b0, u_offx} + {1'b0, u_pw};
  assign end_y = {1'b0, u_offy} + {1'b0, u_ph};
  assign lim_x = {1'b0, cnt_x_d} + {{(COORD_W-3){1'b0}}, u_sx} + LIM_ONE;
  assign lim_y = {1'b0, cnt_y_d} + {{(COORD_W-3){1'b0}}, u_sy} + LIM_ONE;

  assign in_x   = (cnt_x_d >= u_offx) && ({1'b0, cnt_x_d} < end_x);
  assign in_y   = (cnt_y_d >= u_offy) && ({1'b0, cnt_y_d} < end_y);
  assign keep   = in_x & in_y & (phx_d == 4'd0) & (phy_d == 4'd0);
  assign hs_k   = keep & (cnt_x_d == u_offx);
  assign fs_k   = hs_k & (cnt_y_d == u_offy);
  // Last kept column/row: the next decimated position would fall outside the window.
  assign last_k = keep & (lim_x >= end_x) & (lim_y >= end_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      phx_q   <= '0;
      phy_q   <= '0;
      first_q <= 1'b1;
    end else if (acc) begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      phx_q   <= phx_d;
      phy_q   <= phy_d;
      first_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      dat1_q  <= '0;
      usr1_q  <= '0;
      pass1_q <= 1'b0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      dat2_q  <= '0;
      usr2_q  <= '0;
      pass2_q <= 1'b0;
      last2_q <= 1'b0;
    end else if (run) begin
      v1_q    <= in_valid;
      dat1_q  <= in_data;
      usr1_q  <= u_act ? {in_user[7:2], fs_k, hs_k} : in_user;
      pass1_q <= keep | ~u_act;
      last1_q <= last_k & u_act;
      v2_q    <= v1_q;
      dat2_q  <= dat1_q;
      usr2_q  <= usr1_q;
      pass2_q <= pass1_q;
      last2_q <= last1_q;
    end
  end

  assign out_data   = dat2_q;
  assign out_user   = usr2_q;
  assign out_valid  = v2_q & pass2_q;
  assign frame_done = out_valid & in_ready & last2_q;

endmodule

// File: tb/tb_isp_crop_stride.sv
// Scoreboard bench for isp_crop_stride: directed frames with hand-listed expected output beats.
module tb_isp_crop_stride;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] in_data, out_data;
  logic [7:0]  in_user, out_user;
  logic        in_valid, out_ready, out_valid, in_ready, frame_done;
  logic [15:0] isp_ctrl, offx, offy, pw, ph;
  logic [7:0]  step;

  isp_crop_stride dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_user(in_user), .in_valid(in_valid),
    .out_ready(out_ready), .out_data(out_data), .out_user(out_user), .out_valid(out_valid),
    .in_ready(in_ready), .isp_ctrl(isp_ctrl), .isp_out_offset_x(offx), .isp_out_offset_y(offy),
    .isp_out_pixel_x(pw), .isp_out_pixel_y(ph), .isp_crop_step(step), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] d;
    logic [7:0]  u;
    logic        fd;
    int          x;
    int          y;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   lat_en = 0;
  bit   rnd_rdy = 0;
  int   acc_cyc[8][8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] sbd(input int x, input int y);
    return 6'((x + 3 * y + 5) & 63);
  endfunction

  function automatic logic [47:0] pix(input int fid, input int x, input int y);
    return {16'(fid), 16'(y), 16'(x)};
  endfunction

  task automatic exp_px(input int fid, input int x, input int y, input bit fs, input bit hs, input bit fd);
    exp_t e;
    e.d = pix(fid, x, y);
    e.u = {sbd(x, y), fs, hs};
    e.fd = fd;
    e.x = x;
    e.y = y;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  initial begin : ready_drv
    in_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      in_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t        e;
    bit          held;
    logic [47:0] hd;
    logic [7:0]  hu;
    held = 0;
    hd = '0;
    hu = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        held = 0;
        continue;
      end
      if (held) begin
        checks++;
        if (!out_valid || out_data !== hd || out_user !== hu) begin
          errors++;
          $display("FAIL stall_hold: got vld %b data %h user %h, required vld 1 data %h user %h",
                   out_valid, out_data, out_user, hd, hu);
        end
      end
      if (out_valid && in_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %h user %h, required no beat", out_data, out_user);
        end else begin
          e = sb_q.pop_front();
          if (out_data !== e.d || out_user !== e.u || frame_done !== e.fd) begin
            errors++;
            $display("FAIL beat(%0d,%0d): got data %h user %h fd %b, required data %h user %h fd %b",
                     e.x, e.y, out_data, out_user, frame_done, e.d, e.u, e.fd);
          end
          if (lat_en) begin
            checks++;
            if (cyc != acc_cyc[e.y][e.x] + 1) begin
              errors++;
              $display("FAIL latency(%0d,%0d): got cycle %0d, required %0d", e.x, e.y, cyc, acc_cyc[e.y][e.x] + 1);
            end
          end
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done: got 1, required 0");
      end
      held = out_valid && !in_ready;
      hd = out_data;
      hu = out_user;
    end
  end

  task automatic set_cfg(input logic [15:0] c, input int ox, input int oy, input int w, input int h, input logic [7:0] st);
    isp_ctrl = c;
    offx = 16'(ox);
    offy = 16'(oy);
    pw = 16'(w);
    ph = 16'(h);
    step = st;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int fid, input int w, input int h, input bit rv, input int chg_row, input int nox);
    bit r;
    int n;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (y == chg_row && x == 0) begin
          in_valid = 1'b0;
          offx = 16'(nox);
          repeat (3) begin @(posedge clk); #1; end
        end
        if (rv) begin
          while ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b1;
        in_data = pix(fid, x, y);
        in_user = {sbd(x, y), (x == 0 && y == 0), (x == 0)};
        n = 0;
        r = 0;
        do begin
          @(negedge clk);
          r = out_ready;
          @(posedge clk);
          #1;
          n++;
        end while (!r && n < 200);
        if (!r) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout(%0d,%0d): got out_ready 0 for 200 cycles, required 1", x, y);
        end
        acc_cyc[y][x] = cyc;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d beats outstanding, required 0", nm, sb_q.size());
      sb_q.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin : main
    in_valid = 1'b0;
    in_data = '0;
    in_user = '0;
    isp_ctrl = 16'h0081;
    offx = '0;
    offy = '0;
    pw = '0;
    ph = '0;
    step = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_user", 64'(out_user), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_out_ready", 64'(out_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1;

    // 8x4, window (2,1)+(4,2), no decimation
    set_cfg(16'h0081, 2, 1, 4, 2, 8'h00);
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 5; x++)
        exp_px(1, x, y, (x == 2 && y == 1), (x == 2), (x == 5 && y == 2));
    lat_en = 1;
    send_frame(1, 8, 4, 0, -1, 0);
    drain("t1");
    lat_en = 0;

    // full frame, step 0x11
    set_cfg(16'h0081, 0, 0, 8, 4, 8'h11);
    exp_px(2, 0, 0, 1, 1, 0); exp_px(2, 2, 0, 0, 0, 0); exp_px(2, 4, 0, 0, 0, 0); exp_px(2, 6, 0, 0, 0, 0);
    exp_px(2, 0, 2, 0, 1, 0); exp_px(2, 2, 2, 0, 0, 0); exp_px(2, 4, 2, 0, 0, 0); exp_px(2, 6, 2, 0, 0, 1);
    send_frame(2, 8, 4, 0, -1, 0);
    drain("t2");

    // same under random valid and random ready
    rnd_rdy = 1;
    exp_px(3, 0, 0, 1, 1, 0); exp_px(3, 2, 0, 0, 0, 0); exp_px(3, 4, 0, 0, 0, 0); exp_px(3, 6, 0, 0, 0, 0);
    exp_px(3, 0, 2, 0, 1, 0); exp_px(3, 2, 2, 0, 0, 0); exp_px(3, 4, 2, 0, 0, 0); exp_px(3, 6, 2, 0, 0, 1);
    send_frame(3, 8, 4, 1, -1, 0);
    drain("t3");
    rnd_rdy = 0;
    repeat (2) begin @(posedge clk); #1; end

    // bypass: crop enable clear
    set_cfg(16'h0001, 2, 1, 4, 2, 8'h00);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        exp_px(4, x, y, (x == 0 && y == 0), (x == 0), 0);
    send_frame(4, 4, 2, 0, -1, 0);
    drain("bypass");

    // window past right edge: truncated, no frame_done
    set_cfg(16'h0081, 6, 0, 4, 1, 8'h00);
    exp_px(5, 6, 0, 1, 1, 0);
    exp_px(5, 7, 0, 0, 0, 0);
    send_frame(5, 8, 2, 0, -1, 0);
    drain("edge");

    // zero width: nothing out
    set_cfg(16'h0081, 0, 0, 0, 4, 8'h00);
    send_frame(6, 8, 2, 0, -1, 0);
    drain("size0");

    // offset_x moved 1 -> 4 before row 2
    set_cfg(16'h0081, 1, 0, 2, 4, 8'h00);
`ifdef CROP_SHADOW_CFG_EN
    for (int y = 0; y < 4; y++) begin
      exp_px(7, 1, y, (y == 0), 1, 0);
      exp_px(7, 2, y, 0, 0, (y == 3));
    end
`else
    for (int y = 0; y < 2; y++) begin
      exp_px(7, 1, y, (y == 0), 1, 0);
      exp_px(7, 2, y, 0, 0, 0);
    end
    for (int y = 2; y < 4; y++) begin
      exp_px(7, 4, y, 0, 1, 0);
      exp_px(7, 5, y, 0, 0, (y == 3));
    end
`endif
    for (int y = 0; y < 4; y++) begin
      exp_px(8, 4, y, (y == 0), 1, 0);
      exp_px(8, 5, y, 0, 0, (y == 3));
    end
    send_frame(7, 8, 4, 0, 2, 4);
    send_frame(8, 8, 4, 0, -1, 0);
    drain("midframe");

    // reset with both stages occupied
    set_cfg(16'h0081, 0, 0, 8, 4, 8'h00);
    mon_en = 0;
    for (int x = 0; x < 4; x++) begin
      in_valid = 1'b1;
      in_data = pix(10, x, 0);
      in_user = {sbd(x, 0), (x == 0), (x == 0)};
      @(posedge clk);
      #1;
    end
    #2;
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'd0);
    chk("async_reset_out_data", 64'(out_data), 64'd0);
    chk("async_reset_out_ready", 64'(out_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    mon_en = 1;
    set_cfg(16'h0081, 2, 1, 4, 2, 8'h00);
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 5; x++)
        exp_px(9, x, y, (x == 2 && y == 1), (x == 2), (x == 5 && y == 2));
    send_frame(9, 8, 4, 0, -1, 0);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
